icache_dm: RTL
==============

# icache_dm

Direct-mapped instruction cache that answers the fetch stage's instruction lookups. The lookup path is combinational: fetch presents `PC` and gets `icache_r` and `instruction` back in the same cycle. On a miss, the block runs a line-fill state machine against a word-wide backing memory with a request/grant and beat handshake. While the fill is in progress, `icache_r` stays low and fetch stalls on it.

## Interface

Parameters:
- `LINES`, 16 — number of cache lines; must be a power of 2.
- `LINE_WORDS`, 4 — 32-bit words per line; must be a power of 2, at least 2.

Ports:
- `CLK`  in  1  — clock; all state updates on the rising edge.
- `RESET`  in  1  — asynchronous, active-high reset.
- `PC`  in  64  — fetch address; `PC[1:0]` is ignored.
- `FLUSH`  in  1  — invalidate all lines (fence.i); one-cycle pulse.
- `icache_r`  out  1  — `instruction` is valid for the current `PC` (hit).
- `instruction`  out  32  — instruction word; 0 when `icache_r`=0.
- `mem_req`  out  1  — line-fill request to backing memory.
- `mem_addr`  out  64  — line base address; stable while `mem_req`=1.
- `mem_gnt`  in  1  — memory accepts the request this cycle.
- `mem_rvalid`  in  1  — a data beat is present.
- `mem_rdata`  in  32  — beat data; beats arrive in ascending word order.

## Operation

Address split (with OB = log2(`LINE_WORDS`), IB = log2(`LINES`)):
- offset = `PC[2+OB-1:2]`
- index = `PC[2+OB+IB-1:2+OB]`
- tag = `PC[63:2+OB+IB]`
- With the defaults: offset `PC[3:2]`, index `PC[7:4]`, tag `PC[63:8]`.

Storage: per line, a valid bit, a tag, and `LINE_WORDS` words. The valid bits are flops and are reset. Tags and data are not reset.

Hit and output:
- hit = valid[index] && tag[index]==tag && state==IDLE.
- `icache_r` = hit.
- `instruction` = data[index][offset] when hit, otherwise 0.

State machine:
- IDLE
  - If !hit and !`FLUSH`: latch `fill_addr` = `{PC[63:2+OB], zeros}` and go to REQ.
  - If `FLUSH` is asserted: clear all valid bits and stay in IDLE. Flush takes priority over starting a fill.
- REQ
  - `mem_req`=1 and `mem_addr`=`fill_addr`.
  - On `mem_gnt`=1: reset the beat counter and go to FILL.
- FILL
  - `mem_req`=0.
  - Each cycle with `mem_rvalid`=1: write `mem_rdata` to data[fill index][count], then increment count.
  - On the beat where count==`LINE_WORDS`-1: write the tag. Set valid unless `flush_pend` is set. Clear `flush_pend` and go to IDLE.
  - A beat that arrives in any state other than FILL is ignored.

Flush during a fill:
- `FLUSH` in REQ or FILL clears all valid bits immediately and sets `flush_pend`.
- The fill runs to completion, but its line is not marked valid.

Redirect during a fill:
- A change of `PC` during REQ or FILL does not abort the fill.
- After the return to IDLE, the new `PC` is looked up normally and may start another fill.

Misaligned `PC`: `PC[1:0]` is not checked. Fetch flags misaligned addresses itself.

## Timing

Reset values:
- state IDLE, all valid bits 0, `flush_pend` 0, beat counter 0.
- `mem_req`=0, `mem_addr`=0, `icache_r`=0, `instruction`=0.

Asserting `RESET` mid-fill:
- Drops `mem_req` asynchronously.
- Any partial line is left invalid.
- Beats arriving after reset are ignored.

Hit latency: 0 cycles (combinational from `PC`).

Miss latency:
- Cycle 0: miss seen in IDLE.
- Cycle 1: `mem_req` is high. It stays high until the cycle in which `mem_gnt` is sampled high.
- Cycle after the grant cycle: FILL begins. The earliest beat is accepted in that cycle.
- Cycle after the last beat: back in IDLE, and `icache_r`=1 if `PC` still matches the line.
- With an immediate grant and back-to-back beats, miss-to-hit is 2+`LINE_WORDS` cycles (6 with the defaults).

Handshake rules:
- `mem_addr` is held constant from the first `mem_req` cycle through the grant.
- Only one fill is outstanding at a time.

## Test plan

1. Reset: assert `RESET` with `PC`=0x100 → `icache_r`=0, `instruction`=0, `mem_req`=0. Release `RESET` → `mem_req`=1 with `mem_addr`=0x100 on the next edge.
2. Cold miss:
   - Setup: `PC`=0x108; grant immediately; send beats 0x00000013, 0x00100093, 0x00200113, 0x00300193.
   - Response: 6 cycles after the miss, `icache_r`=1 with `instruction`=0x00200113.
   - Then `PC`=0x10C → hit in the same cycle, `instruction`=0x00300193, no `mem_req`.
3. Conflict:
   - After test 2, set `PC`=0x1100 (index 0, different tag) → refill with `mem_addr`=0x1100.
   - Then `PC`=0x100 → miss again and refetch with `mem_addr`=0x100.
4. Backpressure: hold `mem_gnt`=0 for 3 cycles and insert one idle cycle between beats 1 and 2 → `mem_req`/`mem_addr` stable for 4 cycles, `icache_r`=0 throughout, and the line is correct afterwards.
5. Flush:
   - Pulse `FLUSH` in the second FILL cycle of a fill of 0x200 → the fill completes, then `icache_r`=0 and `mem_req` reasserts for 0x200.
   - Pulse `FLUSH` in IDLE with line 0x100 valid → the next lookup of 0x100 misses.
6. Redirect and reset mid-fill:
   - Change `PC` from 0x300 to 0x400 during FILL → the 0x300 fill completes, then `mem_addr`=0x400 is requested.
   - Assert `RESET` after beat 2 → `mem_req`=0 immediately, and 0x300 misses after reset.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with a combinational lookup path
// and a request/grant line-fill engine toward a word-wide backing memory.
module icache_dm #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] PC,
  input  logic        FLUSH,
  output logic        icache_r,
  output logic [31:0] instruction,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 64 - 2 - OB - IB;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];
  logic [63:0]      fill_addr_q;
  logic [OB-1:0]    count_q;
  logic             flush_pend_q;

  logic [OB-1:0] pc_off;
  logic [IB-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic [IB-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          pc_unused;
  logic          hit;
  logic          beat;
  logic          last_beat;

  assign pc_off    = PC[2+OB-1:2];
  assign pc_idx    = PC[2+OB+IB-1:2+OB];
  assign pc_tag    = PC[63:2+OB+IB];
  assign pc_unused = ^PC[1:0];
  assign fill_idx  = fill_addr_q[2+OB+IB-1:2+OB];
  assign fill_tag  = fill_addr_q[63:2+OB+IB];

  assign hit       = (state_q == IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign beat      = (state_q == FILL) && mem_rvalid;
  assign last_beat = beat && (count_q == OB'(LINE_WORDS - 1));

  assign icache_r    = hit;
  assign instruction = hit ? data_mem[pc_idx][pc_off] : 32'h0;
  assign mem_req     = (state_q == REQ);
  assign mem_addr    = fill_addr_q;

  // NOTE: next state gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!hit && !FLUSH) state_d = REQ;
      REQ:     if (mem_gnt)        state_d = FILL;
      FILL:    if (last_beat)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      count_q      <= '0;
      fill_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == REQ)
        fill_addr_q <= {PC[63:2+OB], {(2+OB){1'b0}}};

      if (state_q == REQ && mem_gnt) count_q <= '0;
      else if (beat)                 count_q <= count_q + 1'b1;

      // A flush landing on the final beat also keeps the new line invalid.
      if (FLUSH)                           valid_q           <= '0;
      else if (last_beat && !flush_pend_q) valid_q[fill_idx] <= 1'b1;

      if (last_beat)                     flush_pend_q <= 1'b0;
      else if (FLUSH && state_q != IDLE) flush_pend_q <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (beat)      data_mem[fill_idx][count_q] <= mem_rdata;
    if (last_beat) tag_mem[fill_idx]           <= fill_tag;
  end

endmodule
